modbus_rtu_frame_rx: RTL
========================

Name: modbus_rtu_frame_rx

Overview:
- Sits directly downstream of uart_byte_rx in the Modbus RTU slave.
- Consumes its byte/rx_done stream and delimits RTU frames using the t1.5 / t3.5 silence rules.
- Computes the running CRC-16/MODBUS and forwards each frame byte with its index.
- At the end of each frame, reports frame length and CRC/timing status to the request parser.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line baud rate.
- T15_CYCLES, 37500: inter-character limit in clocks. Derived as 750 us if BAUD_RATE>19200, else 16.5*CLK_FREQ/BAUD_RATE.
- T35_CYCLES, 87500: frame-end silence in clocks. Derived as 1750 us if BAUD_RATE>19200, else 38.5*CLK_FREQ/BAUD_RATE.
- MAX_LEN, 256: maximum frame length in bytes, CRC included.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- rx_data  in  8  received byte, valid with rx_done
- rx_done  in  1  one-cycle pulse per received byte
- slave_addr  in  8  own station address; present only with MODBUS_ADDR_FILTER_EN
- byte_data  out  8  forwarded frame byte
- byte_valid  out  1  one-cycle strobe for byte_data
- byte_idx  out  8  position of byte_data in the frame, 0-based
- frame_done  out  1  one-cycle pulse at frame end
- frame_len  out  9  bytes in the frame; held until the next frame_done
- crc_ok  out  1  CRC residue zero and len>=4; held with frame_len
- frame_err  out  1  gap, overflow or short-frame error; held with frame_len
- busy  out  1  high while in RECV

Behaviour:
- Reset (async, rst_n=0): all outputs 0, CRC=16'hFFFF, state=INIT, silence counter=0.
- Silence counter:
  - Cleared on every rx_done; otherwise increments, saturating at T35_CYCLES.
  - Measures clocks since the last rx_done. The half stop bit is intentionally not compensated.
- INIT: rx_done bytes are ignored. Go to IDLE once the counter reaches T35_CYCLES. This enforces post-reset line silence.
- IDLE: on rx_done, go to RECV.
  - Byte goes out as idx 0.
  - CRC is initialised from FFFF and updated with that byte.
  - len=1, error flags cleared.
- RECV, on each rx_done:
  - If the counter was >T15_CYCLES, set gap_err. Keep absorbing bytes and the CRC.
  - If len==MAX_LEN, set ovf_err, drop the byte (no byte_valid), and keep len at MAX_LEN.
  - Otherwise forward the byte, idx=len, then len+1.
- RECV: when the counter reaches T35_CYCLES, go to DONE.
- DONE (one cycle):
  - frame_done=1.
  - frame_len=len.
  - crc_ok = (crc==0) && len>=4 && !gap_err && !ovf_err.
  - frame_err = gap_err | ovf_err | (len<4).
  - Then go to IDLE.
- Latency: byte_valid/byte_data/byte_idx are registered, asserted exactly one clock after rx_done.
- CRC:
  - Reflected polynomial 0xA001, LSB-first.
  - Updated for all 8 bits combinationally in the cycle rx_done is sampled; the register is valid one clock later.
  - The appended CRC bytes are fed through, so a good frame leaves residue 0.
- rx_done in the same cycle the counter hits T35_CYCLES: the counter reset wins and the frame continues.
- byte_idx is 8 bits. With MAX_LEN=256 the maximum forwarded index is 255, so there is no wrap.
- Reset mid-frame: the frame is aborted with no frame_done, and the block returns to INIT.

Optional Feature:
- Macro MODBUS_ADDR_FILTER_EN.
- Defined:
  - slave_addr port exists.
  - If byte 0 is neither slave_addr nor 8'h00 (broadcast), the frame is absorbed silently: no byte_valid for any byte, no frame_done, and the held outputs are unchanged.
  - Timing rules still apply.
  - The byte 0 decision is made combinationally at rx_done, so there is no extra latency.
- Undefined: no slave_addr port; every frame is forwarded and reported.

Test Plan:
- Post-reset silence: byte 8'h55 at 10 us after reset release → no byte_valid. Then wait 2 ms, send 01 03 00 00 00 01 84 0A back-to-back at 115200 → 8 byte_valid with idx 0..7, then frame_done ~1.75 ms after the last rx_done: frame_len=8, crc_ok=1, frame_err=0.
- CRC fault: same frame with last byte 0B → frame_done, frame_len=8, crc_ok=0, frame_err=0.
- Gap error: 01 03 00, idle 1.0 ms, then 00 00 01 84 0A → one frame_done, frame_len=8, frame_err=1, crc_ok=0.
- Overflow: 300 back-to-back bytes with MAX_LEN=256 → exactly 256 byte_valid (last idx 255), frame_len=256, frame_err=1. Short frame 01 03 → frame_len=2, frame_err=1.
- Reset mid-frame: rst_n low for 5 clocks after byte 3 of the good frame → outputs 0, no frame_done. Following bytes within 1.75 ms are ignored; a later good frame is reported correctly.
- With MODBUS_ADDR_FILTER_EN and slave_addr=8'h11:
  - Good frame to address 01 → no strobes.
  - 11 03 00 00 00 01 86 9A → frame_done, crc_ok=1.
  - Broadcast frame beginning 00 → forwarded.

Source files
------------

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame delimiter: t1.5/t3.5 silence framing, running CRC-16/MODBUS, per-byte forwarding.
// Optional MODBUS_ADDR_FILTER_EN: silently absorb frames not addressed to slave_addr_i or broadcast.
module modbus_rtu_frame_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int T15_CYCLES = (BAUD_RATE > 19200) ? (CLK_FREQ / 4000) * 3
                                                 : ((CLK_FREQ / 2) * 33) / BAUD_RATE,
  parameter int T35_CYCLES = (BAUD_RATE > 19200) ? (CLK_FREQ / 4000) * 7
                                                 : ((CLK_FREQ / 2) * 77) / BAUD_RATE,
  parameter int MAX_LEN    = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
`ifdef MODBUS_ADDR_FILTER_EN
  input  logic [7:0] slave_addr_i,
`endif
  output logic [7:0] byte_data_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_idx_o,
  output logic       frame_done_o,
  output logic [8:0] frame_len_o,
  output logic       crc_ok_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int            CW     = $clog2(T35_CYCLES + 1);
  localparam logic [CW-1:0] T15_C  = CW'(T15_CYCLES);
  localparam logic [CW-1:0] T35_C  = CW'(T35_CYCLES);
  localparam logic [8:0]    MAX_C  = 9'(MAX_LEN);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RECV, S_DONE} state_t;

  // Reflected 0xA001, LSB first, all eight bits in one step.
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [8:0]    len_q, len_d;
  logic          gap_q, gap_d, ovf_q, ovf_d, drop_q, drop_d;
  logic [7:0]    byte_data_q, byte_data_d, byte_idx_q, byte_idx_d;
  logic          byte_valid_q, byte_valid_d, frame_done_q, frame_done_d;
  logic [8:0]    frame_len_q, frame_len_d;
  logic          crc_ok_q, crc_ok_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic          addr_ok_s;

`ifdef MODBUS_ADDR_FILTER_EN
  assign addr_ok_s = (rx_data_i == slave_addr_i) || (rx_data_i == 8'h00);
`else
  assign addr_ok_s = 1'b1;
`endif

  // Next-state, silence counter, CRC and output strobes.
  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    len_d        = len_q;
    gap_d        = gap_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    byte_data_d  = byte_data_q;
    byte_idx_d   = byte_idx_q;
    byte_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_len_d  = frame_len_q;
    crc_ok_d     = crc_ok_q;
    frame_err_d  = frame_err_q;
    if (rx_done_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == T35_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
    case (state_q)
      S_INIT: begin
        if (cnt_q == T35_C && !rx_done_i) state_d = S_IDLE;
        else                              state_d = S_INIT;
      end
      // DONE lasts one cycle and behaves like IDLE, so a byte landing there is not lost.
      S_IDLE, S_DONE: begin
        if (rx_done_i) begin
          state_d      = S_RECV;
          crc_d        = crc16_upd(16'hFFFF, rx_data_i);
          len_d        = 9'd1;
          gap_d        = 1'b0;
          ovf_d        = 1'b0;
          drop_d       = !addr_ok_s;
          byte_valid_d = addr_ok_s;
          byte_data_d  = rx_data_i;
          byte_idx_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        if (rx_done_i) begin
          crc_d = crc16_upd(crc_q, rx_data_i);
          if (cnt_q > T15_C) gap_d = 1'b1;
          else               gap_d = gap_q;
          if (len_q == MAX_C) begin
            ovf_d = 1'b1;
          end else begin
            len_d        = len_q + 9'd1;
            byte_valid_d = !drop_q;
            byte_data_d  = rx_data_i;
            byte_idx_d   = len_q[7:0];
          end
        end else if (cnt_q == T35_C) begin
          state_d = S_DONE;
          if (!drop_q) begin
            frame_done_d = 1'b1;
            frame_len_d  = len_q;
            crc_ok_d     = (crc_q == 16'h0000) && (len_q >= 9'd4) && !gap_q && !ovf_q;
            frame_err_d  = gap_q || ovf_q || (len_q < 9'd4);
          end else begin
            frame_done_d = 1'b0;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      default: state_d = S_INIT;
    endcase
    busy_d = (state_d == S_RECV);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      cnt_q        <= {CW{1'b0}};
      crc_q        <= 16'hFFFF;
      len_q        <= 9'd0;
      gap_q        <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_idx_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= 9'd0;
      crc_ok_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      byte_data_q  <= byte_data_d;
      byte_idx_q   <= byte_idx_d;
      byte_valid_q <= byte_valid_d;
      frame_done_q <= frame_done_d;
      frame_len_q  <= frame_len_d;
      crc_ok_q     <= crc_ok_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign byte_data_o  = byte_data_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_idx_o   = byte_idx_q;
  assign frame_done_o = frame_done_q;
  assign frame_len_o  = frame_len_q;
  assign crc_ok_o     = crc_ok_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule
